// File: rtl/mem_bist_pkg.sv
// Shared types and per-element constants for the March C- BIST controller.
// Element tables are indexed by elem_e, bit i describing element Mi.
package mem_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    M0,
    M1,
    M2,
    M3,
    M4,
    M5
  } elem_e;

  // M0..M2 ascend; M3..M5 descend
  localparam logic [5:0] ELEM_UP     = 6'b000111;
  localparam logic [5:0] ELEM_RD     = 6'b111110;
  localparam logic [5:0] ELEM_WR     = 6'b011111;
  // Polarity 1 means the inverted background (~BG)
  localparam logic [5:0] ELEM_RD_INV = 6'b010100;
  localparam logic [5:0] ELEM_WR_INV = 6'b001010;

  function automatic elem_e next_elem(input elem_e e);
    elem_e n;
    case (e)
      M0:      n = M1;
      M1:      n = M2;
      M2:      n = M3;
      M3:      n = M4;
      M4:      n = M5;
      default: n = M5;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data compare pipeline: holds the expected word for one cycle, then
// checks the RAM output, keeps the first failure and a saturating error count.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int ADDR_BUS = 3,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_rd,
  input  logic                i_discard,
  input  logic [ADDR_BUS-1:0] i_addr,
  input  logic [WIDTH-1:0]    i_exp,
  input  logic [WIDTH-1:0]    i_dout,
  output logic                o_mismatch,
  output logic                o_fail,
  output logic [ADDR_BUS-1:0] o_fail_addr,
  output logic [WIDTH-1:0]    o_fail_exp,
  output logic [WIDTH-1:0]    o_fail_got,
  output logic [CNT_W-1:0]    o_err_count
);

  logic                r_valid;
  logic [WIDTH-1:0]    r_exp;
  logic [ADDR_BUS-1:0] r_addr;
  logic                r_fail;
  logic [ADDR_BUS-1:0] r_fail_addr;
  logic [WIDTH-1:0]    r_fail_exp;
  logic [WIDTH-1:0]    r_fail_got;
  logic [CNT_W-1:0]    r_err_count;
  logic                w_mismatch;

  assign w_mismatch = r_valid && (i_dout != r_exp);

  // A discarded read is the op still in flight when a stop-on-fail halts the run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_exp       <= '0;
      r_addr      <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_err_count <= '0;
    end else if (i_clear) begin
      r_valid     <= 1'b0;
      r_exp       <= '0;
      r_addr      <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_err_count <= '0;
    end else begin
      r_valid <= i_rd && !i_discard;
      r_exp   <= i_exp;
      r_addr  <= i_addr;
      if (w_mismatch) begin
        if (r_err_count != '1) begin
          r_err_count <= r_err_count + 1'b1;
        end
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_addr;
          r_fail_exp  <= r_exp;
          r_fail_got  <= i_dout;
        end
      end
    end
  end

  assign o_mismatch  = w_mismatch;
  assign o_fail      = r_fail;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_got  = r_fail_got;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST master for one dual-port RAM: sequences M0..M5, one address
// per cycle, and decodes the RAM port signals from state/element/address.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               DEPTH        = 8,
  parameter int               ADDR_BUS     = 3,
  parameter logic [WIDTH-1:0] BG           = 16'h0000,
  parameter bit               STOP_ON_FAIL = 1'b0,
  parameter int               CNT_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                fail,
  output logic [ADDR_BUS-1:0] fail_addr,
  output logic [WIDTH-1:0]    fail_exp,
  output logic [WIDTH-1:0]    fail_got,
  output logic [CNT_W-1:0]    err_count,
  output logic                mem_we,
  output logic                mem_re,
  output logic [ADDR_BUS-1:0] mem_wr_addr,
  output logic [ADDR_BUS-1:0] mem_rd_addr,
  output logic [WIDTH-1:0]    mem_din,
  input  logic [WIDTH-1:0]    mem_dout
);

  localparam logic [ADDR_BUS-1:0] LAST_ADDR = ADDR_BUS'(DEPTH - 1);

  state_e              r_state;
  state_e              w_next_state;
  elem_e               r_elem;
  elem_e               w_elem_nxt;
  logic [ADDR_BUS-1:0] r_addr;
  logic                w_start_acc;
  logic                w_run;
  logic                w_up;
  logic                w_last;
  logic                w_mismatch;
  logic                w_stop;
  logic [WIDTH-1:0]    w_wr_data;
  logic [WIDTH-1:0]    w_rd_exp;

  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_run       = (r_state == ST_RUN);
  assign w_up        = ELEM_UP[r_elem];
  assign w_last      = w_up ? (r_addr == LAST_ADDR) : (r_addr == '0);
  assign w_elem_nxt  = next_elem(r_elem);
  assign w_stop      = STOP_ON_FAIL && w_mismatch &&
                       ((r_state == ST_RUN) || (r_state == ST_DRAIN));
  assign w_wr_data   = ELEM_WR_INV[r_elem] ? ~BG : BG;
  assign w_rd_exp    = ELEM_RD_INV[r_elem] ? ~BG : BG;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // DRAIN covers the last read's compare cycle before reporting done
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_RUN;
      ST_RUN: begin
        if (w_stop) begin
          w_next_state = ST_DONE;
        end else if (w_last && (r_elem == M5)) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: w_next_state = ST_DONE;
      ST_DONE:  if (start) w_next_state = ST_RUN;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Element change reloads the address for the new direction, so no wrap is needed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem <= M0;
      r_addr <= '0;
    end else if (w_start_acc) begin
      r_elem <= M0;
      r_addr <= '0;
    end else if (w_run && !w_stop) begin
      if (w_last) begin
        if (r_elem != M5) begin
          r_elem <= w_elem_nxt;
          r_addr <= ELEM_UP[w_elem_nxt] ? '0 : LAST_ADDR;
        end
      end else begin
        r_addr <= w_up ? (r_addr + 1'b1) : (r_addr - 1'b1);
      end
    end
  end

  always_comb begin
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_wr_addr = '0;
    mem_rd_addr = '0;
    mem_din     = '0;
    if (w_run) begin
      mem_we      = ELEM_WR[r_elem];
      mem_re      = ELEM_RD[r_elem];
      mem_wr_addr = r_addr;
      mem_rd_addr = r_addr;
      mem_din     = ELEM_WR[r_elem] ? w_wr_data : '0;
    end
  end

  mem_bist_cmp #(
    .WIDTH   (WIDTH),
    .ADDR_BUS(ADDR_BUS),
    .CNT_W   (CNT_W)
  ) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_start_acc),
    .i_rd       (mem_re),
    .i_discard  (w_stop),
    .i_addr     (r_addr),
    .i_exp      (w_rd_exp),
    .i_dout     (mem_dout),
    .o_mismatch (w_mismatch),
    .o_fail     (fail),
    .o_fail_addr(fail_addr),
    .o_fail_exp (fail_exp),
    .o_fail_got (fail_got),
    .o_err_count(err_count)
  );

  assign busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done = (r_state == ST_DONE);
  assign pass = (r_state == ST_DONE) && !fail;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: three instances (default, stop-on-fail, BG=A5A5),
// each on its own 1-cycle-latency RAM model with an optional stuck-at fault.
module tb_mem_bist_ctrl;

  localparam int W = 16;
  localparam int D = 8;
  localparam int AB = 3;
  localparam int CW = 8;

  typedef struct {
    int          inst;
    int          doneCyc;
    logic        expPass;
    logic        expFail;
    logic [7:0]  expErr;
    logic [2:0]  expAddr;
    logic [15:0] expExp;
    logic [15:0] expGot;
    int          expWr;
    int          expRd;
    int          wrBase;
    int          rdBase;
    logic [15:0] m0Data;
    logic [15:0] m1Data;
  } entry_t;

  entry_t sb[$];
  int cmpCount = 0;
  int failCount = 0;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic startA, busyA, doneA, passA, failA, weA, reA, faultA;
  logic [AB-1:0] faA, waA, raA;
  logic [W-1:0] feA, fgA, dinA, doutA = '0;
  logic [CW-1:0] errA;
  logic [W-1:0] memA [D];
  logic [W-1:0] logA [1024];
  int wrCntA = 0, rdCntA = 0;

  logic startS, busyS, doneS, passS, failS, weS, reS, faultS;
  logic [AB-1:0] faS, waS, raS;
  logic [W-1:0] feS, fgS, dinS, doutS = '0;
  logic [CW-1:0] errS;
  logic [W-1:0] memS [D];
  logic [W-1:0] logS [1024];
  int wrCntS = 0, rdCntS = 0;

  logic startB, busyB, doneB, passB, failB, weB, reB, faultB;
  logic [AB-1:0] faB, waB, raB;
  logic [W-1:0] feB, fgB, dinB, doutB = '0;
  logic [CW-1:0] errB;
  logic [W-1:0] memB [D];
  logic [W-1:0] logB [1024];
  int wrCntB = 0, rdCntB = 0;

  logic prevDoneA = 1'b0, prevDoneS = 1'b0, prevDoneB = 1'b0;

  mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_BUS(AB), .BG(16'h0000),
                  .STOP_ON_FAIL(1'b0), .CNT_W(CW)) dutA (
    .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
    .pass(passA), .fail(failA), .fail_addr(faA), .fail_exp(feA),
    .fail_got(fgA), .err_count(errA), .mem_we(weA), .mem_re(reA),
    .mem_wr_addr(waA), .mem_rd_addr(raA), .mem_din(dinA), .mem_dout(doutA));

  mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_BUS(AB), .BG(16'h0000),
                  .STOP_ON_FAIL(1'b1), .CNT_W(CW)) dutS (
    .clk(clk), .rst(rst), .start(startS), .busy(busyS), .done(doneS),
    .pass(passS), .fail(failS), .fail_addr(faS), .fail_exp(feS),
    .fail_got(fgS), .err_count(errS), .mem_we(weS), .mem_re(reS),
    .mem_wr_addr(waS), .mem_rd_addr(raS), .mem_din(dinS), .mem_dout(doutS));

  mem_bist_ctrl #(.WIDTH(W), .DEPTH(D), .ADDR_BUS(AB), .BG(16'hA5A5),
                  .STOP_ON_FAIL(1'b0), .CNT_W(CW)) dutB (
    .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
    .pass(passB), .fail(failB), .fail_addr(faB), .fail_exp(feB),
    .fail_got(fgB), .err_count(errB), .mem_we(weB), .mem_re(reB),
    .mem_wr_addr(waB), .mem_rd_addr(raB), .mem_din(dinB), .mem_dout(doutB));

  // Read-before-write RAMs; the fault forces bit0 of address 5 high on reads
  always @(posedge clk) begin
    if (weA) begin memA[waA] <= dinA; logA[10'(wrCntA)] <= dinA; wrCntA <= wrCntA + 1; end
    if (reA) begin doutA <= memA[raA] | ((faultA && raA == 3'd5) ? 16'h0001 : 16'h0000); rdCntA <= rdCntA + 1; end
  end

  always @(posedge clk) begin
    if (weS) begin memS[waS] <= dinS; logS[10'(wrCntS)] <= dinS; wrCntS <= wrCntS + 1; end
    if (reS) begin doutS <= memS[raS] | ((faultS && raS == 3'd5) ? 16'h0001 : 16'h0000); rdCntS <= rdCntS + 1; end
  end

  always @(posedge clk) begin
    if (weB) begin memB[waB] <= dinB; logB[10'(wrCntB)] <= dinB; wrCntB <= wrCntB + 1; end
    if (reB) begin doutB <= memB[raB] | ((faultB && raB == 3'd5) ? 16'h0001 : 16'h0000); rdCntB <= rdCntB + 1; end
  end

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput(input int k, input logic done, input logic prev,
                             input logic pass, input logic fail, input logic [7:0] err,
                             input logic [2:0] fa, input logic [15:0] fe, input logic [15:0] fg,
                             input int wrCnt, input int rdCnt, input logic [15:0] wlog [1024]);
    entry_t e;
    int m0Bad;
    if (done && !prev) begin
      if (sb.size() == 0) begin
        cmpCount++;
        failCount++;
        $display("[TB] FAIL unexpected_done: instance %0d raised done with no pending run", k);
      end else begin
        e = sb.pop_front();
        compareVal("instance", 32'(k), 32'(e.inst));
        compareVal("done_cycle", 32'(cyc), 32'(e.doneCyc));
        compareVal("pass", 32'(pass), 32'(e.expPass));
        compareVal("fail", 32'(fail), 32'(e.expFail));
        compareVal("err_count", 32'(err), 32'(e.expErr));
        compareVal("fail_addr", 32'(fa), 32'(e.expAddr));
        compareVal("fail_exp", 32'(fe), 32'(e.expExp));
        compareVal("fail_got", 32'(fg), 32'(e.expGot));
        compareVal("write_ops", 32'(wrCnt - e.wrBase), 32'(e.expWr));
        compareVal("read_ops", 32'(rdCnt - e.rdBase), 32'(e.expRd));
        compareVal("m1_first_din", 32'(wlog[10'(e.wrBase + 8)]), 32'(e.m1Data));
        m0Bad = 0;
        for (int i = 0; i < 8; i++) begin
          if (wlog[10'(e.wrBase + i)] !== e.m0Data) m0Bad++;
        end
        compareVal("m0_din_errors", 32'(m0Bad), 32'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, doneA, prevDoneA, passA, failA, errA, faA, feA, fgA, wrCntA, rdCntA, logA);
    checkOutput(1, doneS, prevDoneS, passS, failS, errS, faS, feS, fgS, wrCntS, rdCntS, logS);
    checkOutput(2, doneB, prevDoneB, passB, failB, errB, faB, feB, fgB, wrCntB, rdCntB, logB);
    prevDoneA <= doneA;
    prevDoneS <= doneS;
    prevDoneB <= doneB;
  end

  function automatic entry_t mkEntry(input int k, input int off, input logic p, input logic f,
                                     input logic [7:0] err, input logic [2:0] fa,
                                     input logic [15:0] fe, input logic [15:0] fg,
                                     input int wr, input int rd,
                                     input logic [15:0] m0, input logic [15:0] m1);
    entry_t e;
    e.inst = k; e.doneCyc = off; e.expPass = p; e.expFail = f; e.expErr = err;
    e.expAddr = fa; e.expExp = fe; e.expGot = fg; e.expWr = wr; e.expRd = rd;
    e.wrBase = 0; e.rdBase = 0; e.m0Data = m0; e.m1Data = m1;
    return e;
  endfunction

  // Pulses start for one edge (E0); doneCyc arrives as an offset from E0
  task automatic applyStimulus(input int k, input entry_t eIn, input bit push, output int e0);
    entry_t e;
    e = eIn;
    @(negedge clk);
    case (k)
      0: begin startA = 1'b1; e.wrBase = wrCntA; e.rdBase = rdCntA; end
      1: begin startS = 1'b1; e.wrBase = wrCntS; e.rdBase = rdCntS; end
      default: begin startB = 1'b1; e.wrBase = wrCntB; e.rdBase = rdCntB; end
    endcase
    @(negedge clk);
    startA = 1'b0;
    startS = 1'b0;
    startB = 1'b0;
    e0 = cyc;
    e.doneCyc = cyc + e.doneCyc;
    if (push) sb.push_back(e);
  endtask

  task automatic waitScoreboard();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      cmpCount++;
      failCount++;
      $display("[TB] FAIL done_timeout: %0d runs still pending after %0d cycles", sb.size(), n);
      sb.delete();
    end
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int e0;
    int wrSnap, rdSnap;
    rst = 1'b1;
    startA = 1'b0; startS = 1'b0; startB = 1'b0;
    faultA = 1'b0; faultS = 1'b0; faultB = 1'b0;
    repeat (3) @(negedge clk);

    compareVal("reset_busy", 32'(busyA), 32'd0);
    compareVal("reset_done", 32'(doneA), 32'd0);
    compareVal("reset_pass", 32'(passA), 32'd0);
    compareVal("reset_fail", 32'(failA), 32'd0);
    compareVal("reset_err", 32'(errA), 32'd0);
    compareVal("reset_we_re", 32'({weA, reA, weS, reS, weB, reB}), 32'd0);
    compareVal("reset_din", 32'(dinB), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    compareVal("idle_done", 32'(doneA), 32'd0);

    $display("[TB] clean run, default BG");
    applyStimulus(0, mkEntry(0, 49, 1'b1, 1'b0, 8'd0, 3'd0, 16'h0000, 16'h0000, 40, 40, 16'h0000, 16'hFFFF), 1'b1, e0);
    @(negedge clk);
    compareVal("busy_in_run", 32'(busyA), 32'd1);
    waitScoreboard();
    repeat (3) @(negedge clk);
    compareVal("done_held", 32'(doneA), 32'd1);
    compareVal("pass_held", 32'(passA), 32'd1);

    $display("[TB] stuck-at-1 at addr 5 bit 0, full run");
    faultA = 1'b1;
    applyStimulus(0, mkEntry(0, 49, 1'b0, 1'b1, 8'd3, 3'd5, 16'h0000, 16'h0001, 40, 40, 16'h0000, 16'hFFFF), 1'b1, e0);
    waitScoreboard();
    faultA = 1'b0;

    $display("[TB] stuck-at-1, stop on first failure");
    faultS = 1'b1;
    applyStimulus(1, mkEntry(1, 15, 1'b0, 1'b1, 8'd1, 3'd5, 16'h0000, 16'h0001, 15, 7, 16'h0000, 16'hFFFF), 1'b1, e0);
    waitScoreboard();
    wrSnap = wrCntS;
    rdSnap = rdCntS;
    repeat (6) @(negedge clk);
    compareVal("stop_no_more_writes", 32'(wrCntS), 32'(wrSnap));
    compareVal("stop_no_more_reads", 32'(rdCntS), 32'(rdSnap));
    compareVal("stop_err_held", 32'(errS), 32'd1);
    faultS = 1'b0;

    $display("[TB] clean run, BG=A5A5");
    applyStimulus(2, mkEntry(2, 49, 1'b1, 1'b0, 8'd0, 3'd0, 16'h0000, 16'h0000, 40, 40, 16'hA5A5, 16'h5A5A), 1'b1, e0);
    waitScoreboard();

    $display("[TB] start pulses during a run");
    applyStimulus(0, mkEntry(0, 49, 1'b1, 1'b0, 8'd0, 3'd0, 16'h0000, 16'h0000, 40, 40, 16'h0000, 16'hFFFF), 1'b1, e0);
    waitUntil(e0 + 9);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitUntil(e0 + 29);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    waitScoreboard();

    $display("[TB] reset in mid-run, then a fresh run");
    applyStimulus(0, mkEntry(0, 49, 1'b1, 1'b0, 8'd0, 3'd0, 16'h0000, 16'h0000, 40, 40, 16'h0000, 16'hFFFF), 1'b0, e0);
    waitUntil(e0 + 19);
    compareVal("pre_reset_busy", 32'(busyA), 32'd1);
    rst = 1'b1;
    wrSnap = wrCntA;
    rdSnap = rdCntA;
    @(negedge clk);
    compareVal("abort_outputs", 32'({busyA, doneA, passA, failA, weA, reA}), 32'd0);
    compareVal("abort_addr_din", 32'({waA, raA, dinA}), 32'd0);
    compareVal("abort_err", 32'(errA), 32'd0);
    compareVal("abort_no_writes", 32'(wrCntA), 32'(wrSnap));
    compareVal("abort_no_reads", 32'(rdCntA), 32'(rdSnap));
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, mkEntry(0, 49, 1'b1, 1'b0, 8'd0, 3'd0, 16'h0000, 16'h0000, 40, 40, 16'h0000, 16'hFFFF), 1'b1, e0);
    waitScoreboard();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
